// File: rtl/dside_req_arbiter.sv
// dside_req_arbiter: shares the bridge data-side port between dcache and uncached path.
// Define DSIDE_ARB_RR_EN for round-robin arbitration instead of uncached-first priority.
module dside_req_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         dc_rd_req,
   input  logic [31:0]  dc_rd_addr,
   output logic         dc_rd_rdy,
   output logic         dc_ret_valid,
   output logic [127:0] dc_ret_data,
   input  logic         dc_wr_req,
   input  logic [31:0]  dc_wr_addr,
   input  logic [127:0] dc_wr_data,
   output logic         dc_wr_rdy,
   input  logic         uc_rd_req,
   input  logic [31:0]  uc_rd_addr,
   output logic         uc_rd_rdy,
   output logic         uc_ret_valid,
   output logic [31:0]  uc_ret_data,
   input  logic         uc_wr_req,
   input  logic [31:0]  uc_wr_addr,
   input  logic [3:0]   uc_wr_wstrb,
   input  logic [31:0]  uc_wr_data,
   output logic         uc_wr_rdy,
   output logic         br_rd_req,
   output logic [2:0]   br_rd_type,
   output logic [31:0]  br_rd_addr,
   input  logic         br_rd_rdy,
   input  logic         br_ret_valid,
   input  logic [127:0] br_ret_data,
   output logic         br_wr_req,
   output logic [2:0]   br_wr_type,
   output logic [31:0]  br_wr_addr,
   output logic [3:0]   br_wr_wstrb,
   output logic [127:0] br_wr_data,
   input  logic         br_wr_rdy
);
   localparam logic [2:0] TY_DC = 3'b100;
   localparam logic [2:0] TY_UC = 3'b010;

   typedef enum logic [1:0] {
      RD_IDLE    = 2'd0,
      RD_WAIT_DC = 2'd1,
      RD_WAIT_UC = 2'd2
   } rd_state_t;

   rd_state_t r_state;
   rd_state_t w_state_nxt;

   logic w_rd_any, w_wr_any;
   logic w_rd_dc, w_wr_dc;
   logic w_rd_acc, w_wr_acc;
   logic w_rd_pref, w_wr_pref;
   logic w_rd_lkv, w_wr_lkv;
   logic r_rd_lk, r_rd_lk_dc;
   logic r_wr_lk, r_wr_lk_dc;

   assign w_rd_any = dc_rd_req | uc_rd_req;
   assign w_wr_any = dc_wr_req | uc_wr_req;

   // a lock only binds while its requester is still asking
   assign w_rd_lkv = r_rd_lk & (r_rd_lk_dc ? dc_rd_req : uc_rd_req);
   assign w_wr_lkv = r_wr_lk & (r_wr_lk_dc ? dc_wr_req : uc_wr_req);

   assign w_rd_dc = w_rd_lkv ? r_rd_lk_dc :
                    (dc_rd_req & uc_rd_req) ? w_rd_pref : dc_rd_req;
   assign w_wr_dc = w_wr_lkv ? r_wr_lk_dc :
                    (dc_wr_req & uc_wr_req) ? w_wr_pref : dc_wr_req;

   assign br_wr_req = resetn & w_wr_any;
   assign br_rd_req = resetn & w_rd_any & ~w_wr_any & (r_state == RD_IDLE);

   assign w_rd_acc = br_rd_req & br_rd_rdy;
   assign w_wr_acc = br_wr_req & br_wr_rdy;

   assign br_rd_type  = w_rd_dc ? TY_DC : TY_UC;
   assign br_rd_addr  = w_rd_dc ? dc_rd_addr : uc_rd_addr;
   assign br_wr_type  = w_wr_dc ? TY_DC : TY_UC;
   assign br_wr_addr  = w_wr_dc ? dc_wr_addr : uc_wr_addr;
   assign br_wr_wstrb = w_wr_dc ? 4'b1111 : uc_wr_wstrb;
   assign br_wr_data  = w_wr_dc ? dc_wr_data : {96'd0, uc_wr_data};

   assign dc_rd_rdy = w_rd_acc & w_rd_dc;
   assign uc_rd_rdy = w_rd_acc & ~w_rd_dc;
   assign dc_wr_rdy = w_wr_acc & w_wr_dc;
   assign uc_wr_rdy = w_wr_acc & ~w_wr_dc;

   assign dc_ret_valid = resetn & br_ret_valid & (r_state == RD_WAIT_DC);
   assign uc_ret_valid = resetn & br_ret_valid & (r_state == RD_WAIT_UC);
   assign dc_ret_data  = br_ret_data;
   assign uc_ret_data  = br_ret_data[31:0];

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= RD_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         RD_IDLE: begin
            if (w_rd_acc) w_state_nxt = w_rd_dc ? RD_WAIT_DC : RD_WAIT_UC;
         end
         RD_WAIT_DC, RD_WAIT_UC: begin
            if (br_ret_valid) w_state_nxt = RD_IDLE;
         end
         default: w_state_nxt = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rd_lk    <= 1'b0;
         r_rd_lk_dc <= 1'b0;
         r_wr_lk    <= 1'b0;
         r_wr_lk_dc <= 1'b0;
      end else begin
         if (br_rd_req && !br_rd_rdy) begin
            r_rd_lk    <= 1'b1;
            r_rd_lk_dc <= w_rd_dc;
         end else if (w_rd_acc) begin
            r_rd_lk    <= 1'b0;
         end
         if (br_wr_req && !br_wr_rdy) begin
            r_wr_lk    <= 1'b1;
            r_wr_lk_dc <= w_wr_dc;
         end else if (w_wr_acc) begin
            r_wr_lk    <= 1'b0;
         end
      end
   end

`ifdef DSIDE_ARB_RR_EN
   logic r_rd_ptr, r_wr_ptr;

   assign w_rd_pref = r_rd_ptr;
   assign w_wr_pref = r_wr_ptr;

   // pointer names the requester favoured next: the one not just granted
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
      end else begin
         if (w_rd_acc) r_rd_ptr <= ~w_rd_dc;
         if (w_wr_acc) r_wr_ptr <= ~w_wr_dc;
      end
   end
`else
   logic [3:0] r_rd_cnt, r_wr_cnt;

   assign w_rd_pref = (r_rd_cnt >= 4'(STARVE_LIMIT));
   assign w_wr_pref = (r_wr_cnt >= 4'(STARVE_LIMIT));

   // counts uncached wins over a waiting dcache; saturates at 15
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rd_cnt <= 4'd0;
         r_wr_cnt <= 4'd0;
      end else begin
         if (w_rd_acc) begin
            if (w_rd_dc)
               r_rd_cnt <= 4'd0;
            else if (dc_rd_req && r_rd_cnt != 4'hF)
               r_rd_cnt <= r_rd_cnt + 4'd1;
         end
         if (w_wr_acc) begin
            if (w_wr_dc)
               r_wr_cnt <= 4'd0;
            else if (dc_wr_req && r_wr_cnt != 4'hF)
               r_wr_cnt <= r_wr_cnt + 4'd1;
         end
      end
   end
`endif

endmodule

// File: doc/dside_req_arbiter.md
# dside_req_arbiter

Shares the single data-side request port of the cache-to-AXI bridge between two requesters: the data cache (line refills and dirty-line writebacks, 4-word bursts) and the uncached load/store path (single-word accesses). It arbitrates reads and writes, keeps at most one read outstanding, and routes the returned read data to whichever requester issued the read. It sits between the dcache/uncache units and the bridge's `data_rd_*`/`data_wr_*` ports; the instruction-side port is not touched.

## Interface
Parameters:
- `STARVE_LIMIT`, default 8: consecutive uncached grants per channel before dcache is forced (fixed-priority mode only); range 1..15.

Ports:
- `clk` in 1: clock
- `resetn` in 1: synchronous, active-low reset
- `dc_rd_req` in 1 / `dc_rd_addr` in 32 / `dc_rd_rdy` out 1: dcache line refill; `dc_rd_addr` is line-aligned
- `dc_ret_valid` out 1 / `dc_ret_data` out 128: refill return
- `dc_wr_req` in 1 / `dc_wr_addr` in 32 / `dc_wr_data` in 128 / `dc_wr_rdy` out 1: dcache writeback
- `uc_rd_req` in 1 / `uc_rd_addr` in 32 / `uc_rd_rdy` out 1: uncached word read
- `uc_ret_valid` out 1 / `uc_ret_data` out 32: uncached read return
- `uc_wr_req` in 1 / `uc_wr_addr` in 32 / `uc_wr_wstrb` in 4 / `uc_wr_data` in 32 / `uc_wr_rdy` out 1: uncached write
- `br_rd_req` out 1 / `br_rd_type` out 3 / `br_rd_addr` out 32 / `br_rd_rdy` in 1: bridge read request
- `br_ret_valid` in 1 / `br_ret_data` in 128: bridge read return
- `br_wr_req` out 1 / `br_wr_type` out 3 / `br_wr_addr` out 32 / `br_wr_wstrb` out 4 / `br_wr_data` out 128 / `br_wr_rdy` in 1: bridge write request

## Operation
- Handshake on every request port: transfer when `req && rdy` in the same cycle. Requesters hold `req` and payload stable until accepted.
- Type encoding: dcache uses `3'b100` (4 words), with `wstrb` forced to `4'b1111` for writes. Uncached uses `3'b010` (1 word), with data on `br_wr_data[31:0]` and `[127:32]` driven to 0.
- Channel selection: `br_rd_req` and `br_wr_req` are never high in the same cycle. A pending write wins over a pending read, so writebacks go ahead of refills.
- Read FSM states:
  - `RD_IDLE`: may issue a read.
  - `RD_WAIT_DC` / `RD_WAIT_UC`: read accepted by the bridge; no further read is issued.
  - Transitions: `RD_IDLE` to `RD_WAIT_x` on `br_rd_req && br_rd_rdy` for requester x; `RD_WAIT_x` to `RD_IDLE` on `br_ret_valid`.
- Return routing:
  - `dc_ret_valid = br_ret_valid && state==RD_WAIT_DC`, with `dc_ret_data = br_ret_data`.
  - `uc_ret_valid = br_ret_valid && state==RD_WAIT_UC`, with `uc_ret_data = br_ret_data[31:0]`.
  - `br_ret_valid` in `RD_IDLE` is dropped.
- Grant lock: each channel has a registered grant lock. When `br_x_req` is presented but not accepted, the lock holds the same requester until accepted; arbitration does not re-evaluate while locked. The lock clears on acceptance.
- Default arbitration: fixed priority, uncached first. A 4-bit per-channel counter increments on each uncached grant while dcache is also requesting, and clears on any dcache grant. At `STARVE_LIMIT`, dcache is granted next.
- Non-granted requester sees `rdy=0`.

## Timing
- Request path is combinational: `br_*` outputs are a mux of the granted requester's inputs. Requester `rdy = br_rdy && granted`, with 0-cycle added latency.
- Return path is combinational: `x_ret_valid` is asserted in the same cycle as `br_ret_valid`.
- Registered state: read FSM, two grant locks, two starvation counters (or two RR pointers).
- Reset values:
  - FSM is `RD_IDLE`; locks, counters and pointers are 0.
  - While `resetn=0`, all `br_*_req`, `*_rdy` and `*_ret_valid` outputs are 0; other outputs are don't-care.
- Reset mid-read: FSM returns to `RD_IDLE`; a late `br_ret_valid` is dropped.
- Simultaneous return and request: `br_ret_valid` in `RD_WAIT_x` returns to `RD_IDLE`. A new read may be issued in the following cycle, not the same cycle.
- Counter saturates at 15; it never wraps.

## Configuration
- `DSIDE_ARB_RR_EN` defined: round-robin per channel. A 1-bit pointer favours the requester not granted last and toggles on each accepted grant. `STARVE_LIMIT` and the counters are unused.
- `DSIDE_ARB_RR_EN` undefined: fixed uncached-first priority with the starvation counter, as described above.

## Test plan
- Uncached read `0x1FC0_0010`: bridge accepts, then 5 cycles later `br_ret_valid` with data `0x..._DEADBEEF`. Expect `uc_ret_valid` high for exactly 1 cycle with `uc_ret_data=0xDEADBEEF`, `dc_ret_valid` low, and `br_rd_type=3'b010`.
- `dc_wr_req` and `dc_rd_req` in the same cycle: write issued first with `br_wr_type=3'b100` and `wstrb=4'b1111`; read issued only after the write is accepted; `br_rd_req`/`br_wr_req` never overlap.
- Read outstanding (`RD_WAIT_DC`) while `uc_rd_req` is asserted: `uc_rd_rdy` stays 0 until the cycle after `br_ret_valid`, then the uncached read is issued.
- `br_rd_rdy` held low for 4 cycles with both read requesters active: `br_rd_addr` stays constant (grant locked) until acceptance.
- Fixed mode, `STARVE_LIMIT=8`, both read requesters continuously active: the 9th read grant goes to dcache. With `DSIDE_ARB_RR_EN` defined, grants alternate UC, DC, UC, DC.
- Assert `resetn=0` during `RD_WAIT_UC`, then inject `br_ret_valid`: no `*_ret_valid` pulse, and FSM is `RD_IDLE`.
